// File: rtl/apb_timer_cfg_master.sv
// Two-requester round-robin APB master sharing the timer's configuration slave port.
// Optional ACCESS-phase timeout is enabled by defining APB_CFG_TIMEOUT_EN.
module apb_timer_cfg_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [19:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [9:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  // state  | meaning
  // IDLE   | bus idle, grant and accept one request
  // SETUP  | psel high, penable low, exactly one cycle
  // ACCESS | psel and penable high, wait for pready (or timeout)
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;
  logic   prio;
  logic   id;
  logic   gnt_any;
  logic   gnt_id;
  logic   timeout_hit;
  logic   done;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef APB_CFG_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt;
  assign timeout_hit = (wait_cnt == TIMEOUT_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  // pready wins over a simultaneous timeout
  assign done = pready | timeout_hit;

  always_comb begin
    gnt_any = |req_valid;
    gnt_id  = 1'b0;
    if (req_valid == 2'b10)
      gnt_id = 1'b1;
    else if (req_valid == 2'b11)
      gnt_id = prio;
    req_ready = 2'b00;
    if (state == IDLE && gnt_any)
      req_ready = gnt_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      id        <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_CFG_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state  <= SETUP;
            psel   <= 1'b1;
            pwrite <= req_write[gnt_id];
            paddr  <= gnt_id ? req_addr[19:10] : req_addr[9:0];
            pwdata <= gnt_id ? req_wdata[63:32] : req_wdata[31:0];
            id     <= gnt_id;
            prio   <= ~gnt_id;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_CFG_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (done) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= id ? 2'b10 : 2'b01;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            rsp_err   <= pready ? pslverr : 1'b1;
          end
`ifdef APB_CFG_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer_cfg_master.sv
// Scoreboard bench for apb_timer_cfg_master: stimulus pushes expected responses,
// a negedge monitor pops and compares them; a simple APB slave model serves the bus.
module tb_apb_timer_cfg_master;
  localparam int TMO = 4;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [19:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb_timer_cfg_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem   [0:1023];
  logic [31:0] slave_mem [0:1023];
  int force_waits = -1;

  function automatic int waits_for(input logic [9:0] a);
    return (force_waits >= 0) ? force_waits : int'(a[1:0]);
  endfunction

  function automatic bit is_err_addr(input logic [9:0] a);
    return a[9:8] == 2'b11;
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input bit p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    logic        err;
    int          access_cycles;
    bit          w;
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  bit   prio_m = 1'b0;
  bit   busy = 1'b0;

  // ---------------- APB slave ----------------
  int s_left = 0;
  always @(posedge pclk) begin
    #1;
    if (psel && !penable) begin
      s_left  = waits_for(paddr);
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (psel && penable) begin
      if (s_left > 0) begin
        s_left--;
        pready  = 1'b0;
        prdata  = $urandom;
      end else begin
        pready  = 1'b1;
        pslverr = is_err_addr(paddr);
        if (pslverr) prdata = {16'hDEAD, 6'd0, paddr};
        else         prdata = slave_mem[paddr];
        if (pwrite && !pslverr) slave_mem[paddr] = pwdata;
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
    end
  end

  // ---------------- monitor ----------------
  bit          rst_prev = 1'b1;
  bit          psel_prev = 1'b0;
  bit          acc_prev = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          access_cnt = 0;
  logic        l_write = 1'b0;
  logic [9:0]  l_addr = '0;
  logic [31:0] l_wdata = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  exp_t        e;
  exp_t        ne;
  logic [1:0]  acc;
  bit          g;
  int          nw;
  bit          tmo;

  always @(negedge pclk) begin
    cyc++;
    if (rst_prev) begin
      chk("reset_outputs", {psel, penable, rsp_valid, rsp_err, rsp_rdata}, '0);
      last_rdata = '0;
      last_err   = 1'b0;
    end else begin
      if (rsp_valid != 2'b00) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", 64'(rsp_valid), e.id ? 64'd2 : 64'd1);
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_latency", 64'(cyc - acc_cyc), 64'(2 + e.access_cycles));
          chk("access_cycles", 64'(access_cnt), 64'(e.access_cycles));
          if (e.w && !e.err) ref_mem[e.a] = e.d;
          last_rdata = e.rdata;
          last_err   = e.err;
        end
        busy = 1'b0;
      end else begin
        chk("rsp_hold", {rsp_err, rsp_rdata}, {last_err, last_rdata});
      end
      if (acc_prev) chk("psel_after_accept", {psel, penable}, 2'b10);
      if (!psel) begin
        chk("apb_idle_zero", {penable, pwrite, paddr, pwdata}, '0);
      end else begin
        chk("apb_ctrl_stable", {pwrite, paddr, pwdata}, {l_write, l_addr, l_wdata});
        if (penable) begin
          chk("access_after_setup", 64'(psel_prev), 64'd1);
          access_cnt++;
        end else begin
          chk("setup_only_after_accept", 64'(acc_prev), 64'd1);
        end
      end
    end
    acc_prev = 1'b0;
    if (preset) begin
      sb_q.delete();
      busy   = 1'b0;
      prio_m = 1'b0;
    end else begin
      chk("req_ready", 64'(req_ready), busy ? 64'd0 : 64'(exp_grant(req_valid, prio_m)));
      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        g    = acc[1];
        ne.id = g;
        ne.w = req_write[g];
        ne.a = g ? req_addr[19:10] : req_addr[9:0];
        ne.d = g ? req_wdata[63:32] : req_wdata[31:0];
        nw   = waits_for(ne.a);
        tmo  = 1'b0;
`ifdef APB_CFG_TIMEOUT_EN
        tmo  = (nw > TMO);
`endif
        ne.err = tmo || is_err_addr(ne.a);
        if (tmo || ne.w)           ne.rdata = '0;
        else if (is_err_addr(ne.a)) ne.rdata = {16'hDEAD, 6'd0, ne.a};
        else                        ne.rdata = ref_mem[ne.a];
        ne.access_cycles = tmo ? TMO + 1 : nw + 1;
        sb_q.push_back(ne);
        grant_log.push_back(int'(g));
        prio_m     = !g;
        busy       = 1'b1;
        acc_prev   = 1'b1;
        acc_cyc    = cyc;
        access_cnt = 0;
        l_write    = ne.w;
        l_addr     = ne.a;
        l_wdata    = ne.d;
      end
    end
    rst_prev  = preset;
    psel_prev = psel;
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+1 after the request is taken.
  task automatic drive_req(input int i, input bit w, input logic [9:0] a, input logic [31:0] d);
    bit ok;
    req_write[i]           = w;
    req_addr[i*10 +: 10]   = a;
    req_wdata[i*32 +: 32]  = d;
    req_valid[i]           = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge pclk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge pclk);
    #1;
    req_valid[i] = 1'b0;
    if (!ok) chk($sformatf("accept_wait_req%0d", i), 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge pclk);
      if (!busy && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_wait", 64'd0, 64'd1);
    @(posedge pclk);
    #1;
  endtask

  task automatic rand_reqs(input int i, input int n);
    logic [9:0] a;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge pclk);
      #1;
      a = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a | 10'h300;
      drive_req(i, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]   = '0;
      slave_mem[i] = '0;
    end
    ref_mem[1]   = 32'h0000ABCD;
    slave_mem[1] = 32'h0000ABCD;

    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    // zero-wait RELOAD write, then a read with three wait states
    force_waits = 0;
    drive_req(0, 1'b1, 10'h002, 32'h0000_0064);
    wait_idle();
    force_waits = 3;
    drive_req(1, 1'b0, 10'h001, 32'h0);
    wait_idle();

    // contention: both requesters keep valid high
    force_waits = 0;
    grant_log.delete();
    fork
      for (int k = 0; k < 2; k++) drive_req(0, 1'b1, 10'(k + 4), $urandom);
      for (int k = 0; k < 2; k++) drive_req(1, 1'b0, 10'(k + 4), 32'h0);
    join
    wait_idle();
    for (int k = 0; k < 4; k++)
      chk($sformatf("contention_grant%0d", k),
          (k < grant_log.size()) ? 64'(grant_log[k]) : 64'hFFFF, 64'(k % 2));

    // slave error followed by normal transfers
    drive_req(0, 1'b1, 10'h300, 32'h1234_5678);
    drive_req(0, 1'b1, 10'h006, 32'h0000_0055);
    drive_req(0, 1'b0, 10'h301, 32'h0);
    drive_req(1, 1'b0, 10'h006, 32'h0);
    wait_idle();

    // reset in the middle of ACCESS
    force_waits = 5;
    drive_req(0, 1'b1, 10'h010, 32'h0000_0077);
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (penable) break;
    end
    @(posedge pclk);
    #1 preset = 1'b1;
    @(posedge pclk);
    #1 preset = 1'b0;
    force_waits = 0;
    grant_log.delete();
    fork
      drive_req(0, 1'b0, 10'h010, 32'h0);
      drive_req(1, 1'b0, 10'h002, 32'h0);
    join
    wait_idle();
    chk("post_reset_first_grant", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hFFFF, 64'd0);

    // randomized traffic, wait states taken from the address
    force_waits = -1;
    fork
      rand_reqs(0, 40);
      rand_reqs(1, 40);
    join
    wait_idle();

`ifdef APB_CFG_TIMEOUT_EN
    force_waits = 1000;
    drive_req(1, 1'b0, 10'h001, 32'h0);
    wait_idle();
    force_waits = TMO;
    drive_req(0, 1'b0, 10'h001, 32'h0);
    wait_idle();
    force_waits = -1;
`endif

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
